// File: rtl/sonar_pkg.sv
// Shared types and 50 MHz timing defaults for the round-robin sonar scheduler.
package sonar_pkg;

   // Scheduler phases for one ping: idle, trigger pulse, wait for echo, measure, dead time.
   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_ECHO,
      S_MEASURE,
      S_GUARD
   } sonar_state_t;

   // Default timing at a 50 MHz clock.
   localparam int DEF_N_SENSORS      = 4;
   localparam int DEF_COUNT_WIDTH    = 32;
   localparam int DEF_TRIG_CYCLES    = 500;      // 10 us trigger pulse
   localparam int DEF_TIMEOUT_CYCLES = 1900000;  // 38 ms echo limit
   localparam int DEF_GUARD_CYCLES   = 3000000;  // 60 ms cross-talk dead time

   // Widest sensor index the scheduler supports (16 sensors).
   localparam int MAX_ID_WIDTH = 4;

   // One completed ping as seen by the distance register block.
   typedef struct packed {
      logic [MAX_ID_WIDTH-1:0]    id;
      logic [DEF_COUNT_WIDTH-1:0] count;
      logic                       timeout;
   } sonar_result_t;

   // Sensor index width; a single sensor still gets a 1-bit index.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// N-bit two-flop synchronizer bringing the raw echo pins into the clk domain.
module sonar_echo_sync
   import sonar_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_all,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two back-to-back flops per bit; the first may go metastable, the second settles it.
   always_ff @(posedge clk or negedge reset_all) begin
      if (!reset_all) begin
         meta <= '0;
         q    <= '0;
      end else begin
         // NOTE: non-blocking so the second flop takes the first flop's pre-edge value.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ping scheduler: triggers one sensor at a time, times its echo,
// reports the width (or a timeout), then holds a guard interval before the next sensor.
module sonar_scheduler
   import sonar_pkg::*;
#(
   parameter int N_SENSORS      = DEF_N_SENSORS,
   parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
   parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES
) (
   input  logic                             clk,
   input  logic                             reset_all,
   input  logic                             enable,
   input  logic [N_SENSORS-1:0]             echo_in,
   output logic [N_SENSORS-1:0]             trig_out,
   output logic                             busy,
   output logic                             result_valid,
   output logic [id_width(N_SENSORS)-1:0]   result_id,
   output logic [COUNT_WIDTH-1:0]           result_count,
   output logic                             result_timeout
);

   localparam int ID_W = id_width(N_SENSORS);

   localparam logic [COUNT_WIDTH-1:0] TRIG_LAST    = COUNT_WIDTH'(TRIG_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] TIMEOUT_CNT  = COUNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] GUARD_LAST   = COUNT_WIDTH'(GUARD_CYCLES - 1);
   localparam logic [ID_W-1:0]        IDX_LAST     = ID_W'(N_SENSORS - 1);

   sonar_state_t           state, state_d;
   logic [ID_W-1:0]        idx, idx_d, idx_next;
   logic [COUNT_WIDTH-1:0] cnt, cnt_d;
   logic [N_SENSORS-1:0]   trig_d;
   logic                   valid_d;
   logic [ID_W-1:0]        id_d;
   logic [COUNT_WIDTH-1:0] count_d;
   logic                   timeout_d;
   logic [N_SENSORS-1:0]   echo_sync;
   logic                   echo_cur;

   sonar_echo_sync #(
      .WIDTH (N_SENSORS)
   ) u_echo_sync (
      .clk       (clk),
      .reset_all (reset_all),
      .d         (echo_in),
      .q         (echo_sync)
   );

   // Only the sensor currently being pinged matters; other echoes are ignored.
   assign echo_cur = echo_sync[idx];
   assign busy     = (state != S_IDLE);
   assign idx_next = (idx == IDX_LAST) ? '0 : idx + ID_W'(1);

   // Counters never wrap: they stick at all-ones.
   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + COUNT_WIDTH'(1);
   endfunction

   function automatic logic [N_SENSORS-1:0] one_hot(input logic [ID_W-1:0] i);
      logic [N_SENSORS-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Next-state, counter, trigger and result decode for the current phase.
   always_comb begin
      // NOTE: every value driven here gets a default first, so no latch is inferred.
      state_d   = state;
      idx_d     = idx;
      cnt_d     = cnt;
      trig_d    = trig_out;
      valid_d   = 1'b0;
      id_d      = result_id;
      count_d   = result_count;
      timeout_d = result_timeout;

      unique case (state)
         S_IDLE: begin
            if (enable) begin
               state_d = S_TRIG;
               cnt_d   = '0;
               trig_d  = one_hot(idx);
            end
         end

         S_TRIG: begin
            if (cnt >= TRIG_LAST) begin
               state_d = S_WAIT_ECHO;
               cnt_d   = '0;
               trig_d  = '0;
            end else begin
               cnt_d = sat_inc(cnt);
            end
         end

         S_WAIT_ECHO: begin
            if (echo_cur) begin
               // The cycle the echo is first seen is echo cycle 1.
               state_d = S_MEASURE;
               cnt_d   = COUNT_WIDTH'(1);
            end else if (cnt >= TIMEOUT_LAST) begin
               state_d   = S_GUARD;
               cnt_d     = '0;
               valid_d   = 1'b1;
               id_d      = idx;
               count_d   = '0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt);
            end
         end

         S_MEASURE: begin
            if (!echo_cur) begin
               state_d   = S_GUARD;
               cnt_d     = '0;
               valid_d   = 1'b1;
               id_d      = idx;
               count_d   = cnt;
               timeout_d = 1'b0;
            end else if (sat_inc(cnt) >= TIMEOUT_CNT) begin
               // Echo stuck high: report the limit as the width.
               state_d   = S_GUARD;
               cnt_d     = '0;
               valid_d   = 1'b1;
               id_d      = idx;
               count_d   = TIMEOUT_CNT;
               timeout_d = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt);
            end
         end

         S_GUARD: begin
            if (cnt >= GUARD_LAST) begin
               idx_d = idx_next;
               cnt_d = '0;
               if (enable) begin
                  state_d = S_TRIG;
                  trig_d  = one_hot(idx_next);
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = sat_inc(cnt);
            end
         end

         default: begin
            state_d = S_IDLE;
            trig_d  = '0;
         end
      endcase
   end

   // State, counter, registered trigger pins and result registers.
   always_ff @(posedge clk or negedge reset_all) begin
      if (!reset_all) begin
         state          <= S_IDLE;
         idx            <= '0;
         cnt            <= '0;
         trig_out       <= '0;
         result_valid   <= 1'b0;
         result_id      <= '0;
         result_count   <= '0;
         result_timeout <= 1'b0;
      end else begin
         state          <= state_d;
         idx            <= idx_d;
         cnt            <= cnt_d;
         trig_out       <= trig_d;
         result_valid   <= valid_d;
         result_id      <= id_d;
         result_count   <= count_d;
         result_timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler: a sensor model answers each trigger
// with a chosen echo and a ping-level reference model predicts every result.
module tb_sonar_scheduler;
   import sonar_pkg::*;

   localparam int N     = 4;
   localparam int CW    = 32;
   localparam int TRIG  = 4;
   localparam int TMO   = 64;
   localparam int GUARD = 8;

   typedef enum int {P_NONE, P_PULSE, P_GHOST} ping_mode_t;

   logic          clk = 1'b0;
   logic          reset_all = 1'b0;
   logic          enable = 1'b0;
   logic [N-1:0]  echo_in = '0;
   logic [N-1:0]  trig_out;
   logic          busy;
   logic          result_valid;
   logic [1:0]    result_id;
   logic [CW-1:0] result_count;
   logic          result_timeout;

   sonar_scheduler #(
      .N_SENSORS      (N),
      .COUNT_WIDTH    (CW),
      .TRIG_CYCLES    (TRIG),
      .TIMEOUT_CYCLES (TMO),
      .GUARD_CYCLES   (GUARD)
   ) dut (
      .clk            (clk),
      .reset_all      (reset_all),
      .enable         (enable),
      .echo_in        (echo_in),
      .trig_out       (trig_out),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_id      (result_id),
      .result_count   (result_count),
      .result_timeout (result_timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int exp_idx = 0;
   int rv_cyc = 0;
   int dly [N];
   int hi [N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Sensor model: after dly[i] more cycles the pin goes high for hi[i] cycles.
   task automatic drive_bit(input int i);
      if (dly[i] > 0) begin
         dly[i]--;
         echo_in[i] = 1'b0;
      end else if (hi[i] > 0) begin
         echo_in[i] = 1'b1;
         hi[i]--;
      end else begin
         echo_in[i] = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) drive_bit(i);
      if (reset_all) check("trig_onehot", $onehot0(trig_out), 1);
   endtask

   task automatic arm(input int i, input int d, input int w);
      dly[i] = d;
      hi[i]  = w;
      drive_bit(i);
   endtask

   // Ping-level reference: echo seen 2 cycles after the raw pin; the wait window
   // is TMO cycles; widths of TMO or more are reported as a timeout at TMO.
   function automatic sonar_result_t expect_result(input ping_mode_t mode, input int idx,
                                                   input int d, input int w);
      sonar_result_t r;
      r.id      = MAX_ID_WIDTH'(idx);
      r.count   = '0;
      r.timeout = 1'b1;
      if (mode == P_PULSE && d + 2 < TMO) begin
         r.count   = (w >= TMO) ? CW'(TMO) : CW'(w);
         r.timeout = (w >= TMO);
      end else if (mode == P_GHOST) begin
         // Raw pin rises in the first trigger cycle; two of its cycles land in the trigger.
         r.count   = CW'(w - 2);
         r.timeout = 1'b0;
      end
      return r;
   endfunction

   task automatic do_ping(input ping_mode_t mode, input int d, input int w,
                          input bit chk_guard, input int drop_at);
      sonar_result_t exp_r;
      int budget;
      int width;
      int fall;
      bit seen;
      exp_r = expect_result(mode, exp_idx, d, w);

      budget = 0;
      while (trig_out == '0 && budget < 400) begin
         tick();
         budget++;
      end
      if (trig_out == '0) begin
         check("trig_wait_expired", 0, 1);
         return;
      end
      check("trig_sel", trig_out, 64'(1) << exp_idx);
      if (chk_guard) check("guard_gap", cyc - rv_cyc, GUARD);
      if (mode == P_GHOST) arm(exp_idx, 0, w);

      width = 0;
      while (trig_out != '0 && width < 50) begin
         width++;
         tick();
      end
      check("trig_len", width, TRIG);

      if (mode == P_PULSE) arm(exp_idx, d, w);
      fall   = cyc;
      seen   = 1'b0;
      budget = 0;
      while (!seen && budget < 300) begin
         if (result_valid) begin
            seen = 1'b1;
         end else begin
            if (drop_at == budget) enable = 1'b0;
            tick();
            budget++;
         end
      end
      if (!seen) begin
         check("result_wait_expired", 0, 1);
         return;
      end
      rv_cyc = cyc;
      check("result_id", result_id, exp_r.id);
      check("result_count", result_count, exp_r.count);
      check("result_timeout", result_timeout, exp_r.timeout);
      if (mode == P_NONE) check("timeout_latency", cyc - fall, TMO);
      tick();
      check("valid_one_cycle", result_valid, 0);
      exp_idx = (exp_idx + 1) % N;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      ping_mode_t m;
      int d;
      int w;
      int budget;
      for (int i = 0; i < N; i++) begin
         dly[i] = 0;
         hi[i]  = 0;
      end

      // Reset values.
      repeat (3) tick();
      check("rst_trig", trig_out, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_id", result_id, 0);
      check("rst_count", result_count, 0);
      check("rst_timeout", result_timeout, 0);

      // Released but not enabled: stays idle.
      reset_all = 1'b1;
      repeat (3) tick();
      check("idle_busy", busy, 0);
      check("idle_trig", trig_out, 0);

      // Directed pings across all sensors and the boundaries.
      enable = 1'b1;
      do_ping(P_PULSE, 10, 20, 1'b0, -1);  // sensor 0, nominal echo
      do_ping(P_NONE, 0, 0, 1'b1, -1);     // sensor 1, no echo
      do_ping(P_PULSE, 3, 100, 1'b1, -1);  // sensor 2, stuck high
      do_ping(P_PULSE, 0, 63, 1'b1, -1);   // sensor 3, just under the limit
      do_ping(P_PULSE, 40, 1, 1'b1, -1);   // sensor 0, single-cycle echo
      do_ping(P_PULSE, 20, 64, 1'b1, -1);  // sensor 1, exactly the limit
      do_ping(P_GHOST, 0, 12, 1'b1, -1);   // sensor 2, echo already high
      do_ping(P_PULSE, 61, 5, 1'b1, -1);   // sensor 3, echo in last wait cycle
      do_ping(P_PULSE, 62, 5, 1'b1, -1);   // sensor 0, echo one cycle too late

      // Drop enable while measuring sensor 1: ping and guard still complete.
      do_ping(P_PULSE, 5, 30, 1'b1, 15);
      repeat (GUARD - 2) tick();
      check("drop_busy_in_guard", busy, 1);
      tick();
      check("drop_busy_fell", busy, 0);
      repeat (20) tick();
      check("drop_idle_busy", busy, 0);
      check("drop_idle_trig", trig_out, 0);
      enable = 1'b1;
      do_ping(P_PULSE, 8, 25, 1'b0, -1);   // resumes at sensor 2

      // Randomized pings.
      for (int k = 0; k < 16; k++) begin
         m = ping_mode_t'($urandom_range(0, 2));
         d = $urandom_range(0, 40);
         w = (m == P_GHOST) ? $urandom_range(3, 40) : $urandom_range(1, 100);
         do_ping(m, d, w, 1'b1, -1);
      end

      // Reset in the middle of a trigger pulse.
      budget = 0;
      while (trig_out == '0 && budget < 100) begin
         tick();
         budget++;
      end
      tick();
      check("trig_before_reset", trig_out != '0, 1);
      reset_all = 1'b0;
      #1;
      check("async_rst_trig", trig_out, 0);
      check("async_rst_busy", busy, 0);
      for (int i = 0; i < N; i++) begin
         dly[i] = 0;
         hi[i]  = 0;
      end
      echo_in = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("no_result_in_reset", result_valid, 0);
      end
      reset_all = 1'b1;
      exp_idx   = 0;
      do_ping(P_PULSE, 4, 9, 1'b0, -1);    // restarts at sensor 0

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
